// File: rtl/accel_position_integrator.sv
// rtl/accel_position_integrator.sv - tilt-to-position integrator
// Averages raw accelerometer samples, applies a deadzone and gain, and integrates a clamped square position once per frame tick.
module accel_position_integrator #(
  parameter int TICK_CYCLES = 833333,
  parameter int AVG_LOG2    = 2,
  parameter int DEADZONE    = 8,
  parameter int GAIN_SHIFT  = 4,
  parameter int X_MAX       = 623,
  parameter int Y_MAX       = 463,
  parameter int X_INIT      = 312,
  parameter int Y_INIT      = 232
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       recenter,
  input  logic [8:0] accel_x_in,
  input  logic [8:0] accel_y_in,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       pos_valid,
  output logic       at_edge_x,
  output logic       at_edge_y
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 9 + AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [9:0] X_MAX_V  = 10'(X_MAX);
  localparam logic [9:0] Y_MAX_V  = 10'(Y_MAX);
  localparam logic [9:0] X_INIT_V = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_V = 10'(Y_INIT);

  typedef enum logic [1:0] {IDLE, SAMPLE, FILTER, UPDATE} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DEPTH-1:0][8:0]       win_x_q, win_x_d;
  logic [DEPTH-1:0][8:0]       win_y_q, win_y_d;
  logic [SUM_W-1:0]            sum_x_q, sum_x_d;
  logic [SUM_W-1:0]            sum_y_q, sum_y_d;
  logic [SUM_W-1:0]            win_sum_x, win_sum_y;
  logic [9:0]                  pos_x_q, pos_x_d;
  logic [9:0]                  pos_y_q, pos_y_d;
  logic                        edge_x_q, edge_x_d;
  logic                        edge_y_q, edge_y_d;
  logic                        valid_q, valid_d;
  logic                        tick;
  logic [10:0]                 upd_x, upd_y;

  // Returns {clamped, new_pos} for one axis from its registered window sum.
  function automatic logic [10:0] next_axis(input logic [9:0] pos,
                                            input logic [SUM_W-1:0] sum,
                                            input logic [9:0] max_v);
    logic [8:0]         avg;
    logic signed [9:0]  offset;
    logic signed [9:0]  vel;
    logic [9:0]         mag;
    logic signed [11:0] nxt;
    logic [10:0]        res;
    avg    = sum[AVG_LOG2 +: 9];
    offset = $signed({1'b0, avg} - 10'd256);
    mag    = offset[9] ? $unsigned(-offset) : $unsigned(offset);
    vel    = (mag <= 10'(DEADZONE)) ? 10'sd0 : (offset >>> GAIN_SHIFT);
    nxt    = $signed({2'b00, pos}) + $signed({{2{vel[9]}}, vel});
    if (nxt < 12'sd0) begin
      res = {1'b1, 10'd0};
    end else if (nxt > $signed({2'b00, max_v})) begin
      res = {1'b1, max_v};
    end else begin
      res = {1'b0, nxt[9:0]};
    end
    return res;
  endfunction

  assign tick = enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    win_sum_x = '0;
    win_sum_y = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win_sum_x = win_sum_x + SUM_W'(win_x_q[i]);
      win_sum_y = win_sum_y + SUM_W'(win_y_q[i]);
    end
  end

  assign upd_x = next_axis(pos_x_q, sum_x_q, X_MAX_V);
  assign upd_y = next_axis(pos_y_q, sum_y_q, Y_MAX_V);

  // The window loads on the tick edge, so SAMPLE starts with the fresh samples already in place.
  always_comb begin
    state_d  = state_q;
    win_x_d  = win_x_q;
    win_y_d  = win_y_q;
    sum_x_d  = sum_x_q;
    sum_y_d  = sum_y_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    edge_x_d = edge_x_q;
    edge_y_d = edge_y_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          for (int i = DEPTH - 1; i > 0; i--) begin
            win_x_d[i] = win_x_q[i-1];
            win_y_d[i] = win_y_q[i-1];
          end
          win_x_d[0] = accel_x_in;
          win_y_d[0] = accel_y_in;
          state_d    = SAMPLE;
        end
      end
      SAMPLE: begin
        sum_x_d = win_sum_x;
        sum_y_d = win_sum_y;
        state_d = FILTER;
      end
      FILTER: begin
        pos_x_d  = upd_x[9:0];
        edge_x_d = upd_x[10];
        pos_y_d  = upd_y[9:0];
        edge_y_d = upd_y[10];
        valid_d  = 1'b1;
        state_d  = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (recenter) begin
      state_d  = IDLE;
      win_x_d  = win_x_q;
      win_y_d  = win_y_q;
      pos_x_d  = X_INIT_V;
      pos_y_d  = Y_INIT_V;
      edge_x_d = 1'b0;
      edge_y_d = 1'b0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_x_q  <= {DEPTH{9'd256}};
      win_y_q  <= {DEPTH{9'd256}};
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      pos_x_q  <= X_INIT_V;
      pos_y_q  <= Y_INIT_V;
      edge_x_q <= 1'b0;
      edge_y_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_x_q  <= win_x_d;
      win_y_q  <= win_y_d;
      sum_x_q  <= sum_x_d;
      sum_y_q  <= sum_y_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      edge_x_q <= edge_x_d;
      edge_y_q <= edge_y_d;
      valid_q  <= valid_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_valid = valid_q;
  assign at_edge_x = edge_x_q;
  assign at_edge_y = edge_y_q;

endmodule

// File: tb/tb_accel_position_integrator.sv
// tb/tb_accel_position_integrator.sv - bench for accel_position_integrator
// Behavioural reference model plus directed and randomized stimulus.
module tb_accel_position_integrator;
  localparam int TICK = 8;

  logic       clock = 1'b0;
  logic       reset, enable, recenter;
  logic [8:0] accel_x_in, accel_y_in;
  logic [9:0] pos_x, pos_y;
  logic       pos_valid, at_edge_x, at_edge_y;

  accel_position_integrator #(.TICK_CYCLES(TICK)) dut (
    .clock(clock), .reset(reset), .enable(enable), .recenter(recenter),
    .accel_x_in(accel_x_in), .accel_y_in(accel_y_in),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .at_edge_x(at_edge_x), .at_edge_y(at_edge_y)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame counter, 4-deep windows, pending result shown 3 cycles after a tick.
  int m_cnt, m_wait;
  int m_wx[4], m_wy[4];
  int m_px, m_py, m_nx, m_ny;
  bit m_ex, m_ey, m_nex, m_ney, m_valid;
  wire m_tick = enable && (m_cnt == TICK - 1);

  function automatic int raw_next(int pos, int sum);
    int avg, off, vel;
    avg = sum / 4;
    off = avg - 256;
    if (off <= 8 && off >= -8) vel = 0;
    else if (off >= 0) vel = off / 16;
    else vel = -((-off + 15) / 16);
    return pos + vel;
  endfunction

  function automatic int clampv(int v, int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_wait <= 0; m_valid <= 0;
      m_px <= 312; m_py <= 232; m_ex <= 0; m_ey <= 0;
      m_nx <= 0; m_ny <= 0; m_nex <= 0; m_ney <= 0;
      for (int i = 0; i < 4; i++) begin m_wx[i] <= 256; m_wy[i] <= 256; end
    end else begin
      m_cnt <= !enable ? 0 : ((m_cnt == TICK - 1) ? 0 : m_cnt + 1);
      if (recenter) begin
        m_px <= 312; m_py <= 232; m_ex <= 0; m_ey <= 0;
        m_wait <= 0; m_valid <= 0;
      end else begin
        m_valid <= (m_wait == 1);
        if (m_wait == 1) begin
          m_px <= m_nx; m_py <= m_ny; m_ex <= m_nex; m_ey <= m_ney;
        end
        if (m_tick && m_wait == 0 && !m_valid) begin
          for (int i = 0; i < 3; i++) begin m_wx[i] <= m_wx[i+1]; m_wy[i] <= m_wy[i+1]; end
          m_wx[3] <= accel_x_in;
          m_wy[3] <= accel_y_in;
          m_nx  <= clampv(raw_next(m_px, m_wx[1] + m_wx[2] + m_wx[3] + accel_x_in), 623);
          m_nex <= (clampv(raw_next(m_px, m_wx[1] + m_wx[2] + m_wx[3] + accel_x_in), 623)
                    != raw_next(m_px, m_wx[1] + m_wx[2] + m_wx[3] + accel_x_in));
          m_ny  <= clampv(raw_next(m_py, m_wy[1] + m_wy[2] + m_wy[3] + accel_y_in), 463);
          m_ney <= (clampv(raw_next(m_py, m_wy[1] + m_wy[2] + m_wy[3] + accel_y_in), 463)
                    != raw_next(m_py, m_wy[1] + m_wy[2] + m_wy[3] + accel_y_in));
          m_wait <= 2;
        end else if (m_wait > 0) begin
          m_wait <= m_wait - 1;
        end
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && chk_en) begin
      check("pos_x", pos_x, m_px);
      check("pos_y", pos_y, m_py);
      check("pos_valid", pos_valid, m_valid);
      check("at_edge_x", at_edge_x, m_ex);
      check("at_edge_y", at_edge_y, m_ey);
    end
  end

  task automatic wait_valid(output int when);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!pos_valid && n < 40);
    check("valid_seen", pos_valid, 1);
    when = cyc;
  endtask

  task automatic n_valids(input int n);
    int w;
    for (int i = 0; i < n; i++) wait_valid(w);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, pos_x, 312);
    check({tag, "_y"}, pos_y, 232);
    check({tag, "_v"}, pos_valid, 0);
    check({tag, "_ex"}, at_edge_x, 0);
    check({tag, "_ey"}, at_edge_y, 0);
  endtask

  task automatic wait_model_wait(input int v);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (m_wait != v && n < 40);
    check("model_phase_seen", m_wait, v);
  endtask

  int t0, t1, t2, vcount;
  int ramp[4] = '{313, 315, 318, 322};

  initial begin
    reset = 1; enable = 0; recenter = 0; accel_x_in = 256; accel_y_in = 256;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 0; enable = 1; chk_en = 1;

    wait_valid(t0); wait_valid(t1); wait_valid(t2);
    check("idle_period1", t1 - t0, TICK);
    check("idle_period2", t2 - t1, TICK);
    check("idle_x", pos_x, 312);
    check("idle_y", pos_y, 232);

    accel_x_in = 259;
    n_valids(10);
    check("dead_x", pos_x, 312);
    check("dead_edge", at_edge_x, 0);

    reset = 1; accel_x_in = 320;
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(t0);
      check("ramp_x", pos_x, ramp[i]);
    end
    wait_valid(t0);
    check("ramp_x5", pos_x, 326);

    accel_x_in = 511;
    n_valids(30);
    check("sat_hi_x", pos_x, 623);
    check("sat_hi_edge", at_edge_x, 1);
    accel_x_in = 0;
    n_valids(50);
    check("sat_lo_x", pos_x, 0);
    check("sat_lo_edge", at_edge_x, 1);

    wait_model_wait(2);
    recenter = 1;
    @(negedge clock);
    recenter = 0;
    check("recenter_x", pos_x, 312);
    check("recenter_y", pos_y, 232);
    check("recenter_edge", at_edge_x, 0);
    vcount = 0;
    repeat (4) begin @(negedge clock); vcount += pos_valid; end
    check("recenter_no_valid", vcount, 0);
    wait_valid(t0);
    check("after_recenter_x", pos_x, 296);

    accel_x_in = 511;
    n_valids(3);
    wait_model_wait(1);
    #1 reset = 1;
    #1 check_reset_vals("async_reset");
    @(negedge clock);
    reset = 0;

    accel_x_in = 400;
    n_valids(2);
    t0 = pos_x;
    enable = 0;
    vcount = 0;
    repeat (20) begin @(negedge clock); vcount += pos_valid; end
    check("disabled_no_valid", vcount, 0);
    check("disabled_hold_x", pos_x, t0);
    enable = 1;

    repeat (600) begin
      @(negedge clock);
      if (m_cnt >= 1 && m_cnt <= TICK - 3 && $urandom_range(0, 2) == 0) begin
        accel_x_in = 9'($urandom_range(0, 511));
        accel_y_in = 9'($urandom_range(0, 511));
      end
      recenter = ($urandom_range(0, 40) == 0);
      enable = ($urandom_range(0, 50) != 0);
    end
    recenter = 0; enable = 1;
    repeat (4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
